// File: rtl/tc_share_arb.sv
// Round-robin arbiter time-sharing one W-bit two's-complement negate unit among NREQ requesters.
// Define TC_OVF_FLAG_EN to add the rsp_ovf output, which flags negation of the most-negative operand.
module tc_share_arb #(
   parameter int NREQ = 4,
   parameter int W    = 25,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id,
`ifdef TC_OVF_FLAG_EN
   output logic              rsp_ovf,
`endif
   output logic              busy
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

   state_t         r_state;
   state_t         w_state_next;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_id;
   logic [W-1:0]   r_data;

   logic [W-1:0]   w_ops [NREQ];
   logic [IDW-1:0] w_idx [NREQ];
   logic [IDW-1:0] w_gidx;
   logic [IDW-1:0] w_ptr_next;
   logic           w_found;
   logic           w_space;
   logic           w_accept;
   logic [W-1:0]   w_opnd;
   logic [W-1:0]   w_neg;

   // w_idx[k] is the requester examined k-th in the rotation starting at r_ptr.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         logic [IDW:0] w_sum;
         assign w_ops[gi]     = req_data[gi*W +: W];
         assign w_sum         = {1'b0, r_ptr} + (IDW+1)'(gi);
         assign w_idx[gi]     = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : w_sum[IDW-1:0];
         assign req_ready[gi] = w_accept && (w_gidx == IDW'(gi));
      end
   endgenerate

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req_valid[w_idx[k]]) begin
            w_found = 1'b1;
            w_gidx  = w_idx[k];
         end
      end
   end

   // Gating with rst_n keeps every grant low while reset is held.
   assign w_space    = (r_state == EMPTY) || rsp_ready;
   assign w_accept   = rst_n && w_space && w_found;
   assign w_opnd     = w_ops[w_gidx];
   assign w_neg      = ~w_opnd + W'(1);
   assign w_ptr_next = (w_gidx == LAST_ID) ? '0 : w_gidx + IDW'(1);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         EMPTY:   if (w_accept) w_state_next = FULL;
         FULL:    if (!w_accept && rsp_ready) w_state_next = EMPTY;
         default: w_state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_ptr   <= '0;
         r_id    <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_data <= w_neg;
            r_id   <= w_gidx;
            r_ptr  <= w_ptr_next;
         end
      end
   end

`ifdef TC_OVF_FLAG_EN
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   logic r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= (w_opnd == MOST_NEG);
      end
   end

   assign rsp_ovf = r_ovf;
`endif

   assign rsp_valid = (r_state == FULL);
   assign rsp_data  = r_data;
   assign rsp_id    = r_id;
   assign busy      = (r_state == FULL) || (|req_valid);

endmodule

// File: doc/tc_share_arb.md
Name: tc_share_arb

Overview:
Round-robin arbiter and sequencer that time-shares one W-bit two's-complement (negate) datapath among NREQ requesters in the FP multiply/add path, e.g. mantissa, exponent-difference and sign-fixup units.
- Each requester presents an operand with a valid/ready handshake.
- The winner is negated and held in a single-entry output register, tagged with the requester id, until the consumer takes it.
- Throughput is one result per cycle when the consumer does not stall.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 25, operand/result width in bits
IDW, $clog2(NREQ), width of rsp_id

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester grant/accept (one-hot or zero)
req_data  in  NREQ*W  operands; requester i occupies bits [i*W +: W]
rsp_valid  out  1  result register holds valid data
rsp_ready  in  1  consumer accepts result
rsp_data  out  W  (~operand + 1) mod 2^W
rsp_id  out  IDW  index of the requester that produced rsp_data
busy  out  1  high when rsp_valid=1 or any req_valid=1

Behaviour:
Reset (rst_n=0, asynchronous):
- rsp_valid=0, rsp_data=0, rsp_id=0, round-robin pointer ptr=0.
- req_ready is 0 during reset.
- An in-flight result is discarded, with no partial output.

States:
- EMPTY (rsp_valid=0)
- FULL (rsp_valid=1)

Space available:
- space = !rsp_valid || rsp_ready.

Grant (combinational):
- If space=1, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (wrap modulo NREQ).
- req_ready = one-hot grant; all zeros if space=0 or no request.

Handshake:
- A transfer occurs on req_valid[i] && req_ready[i] at the clock edge.
- req_ready never depends on req_data.
- A requester holds req_valid and req_data stable until accepted.

Accept at edge k:
- rsp_data <= ~req_data[g] + 1 (W-bit, carry out dropped); rsp_id <= g; rsp_valid <= 1; ptr <= (g+1) mod NREQ.
- Latency is exactly 1 cycle: result visible after edge k.

Drain:
- rsp_valid && rsp_ready at an edge with no new accept gives rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Drain and accept in the same edge: the register is overwritten with the new result and rsp_valid stays 1. No bubble, no loss.

Transitions:
- EMPTY->FULL on accept.
- FULL->FULL on accept+drain, or on stall (rsp_ready=0, with rsp_data, rsp_id and rsp_valid stable).
- FULL->EMPTY on drain without accept.

Other rules:
- ptr changes only on accept.
- Fairness: a continuously asserted requester waits at most NREQ-1 grants.

Arithmetic boundaries:
- Operand 0 gives 0.
- Operand 2^(W-1) gives 2^(W-1), the most-negative case.
- All-ones gives 1.

Optional Feature:
Macro TC_OVF_FLAG_EN.
- Defined: adds output port rsp_ovf (1 bit), registered alongside rsp_data.
  - rsp_ovf=1 when the accepted operand equals 2^(W-1), since the negation is unrepresentable; otherwise 0.
  - Reset value 0; held while stalled; same drain/overwrite rules as rsp_data.
- Undefined: the port is absent and no overflow logic is built. All other behaviour is identical.

Test Plan:
1. Reset release, req_valid=0001, req_data[0]=25'd1, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=25'h1FFFFFF, rsp_id=0, then rsp_valid=0.
2. All four requesters valid continuously with operands 1,2,3,4, rsp_ready=1 -> grants in order 0,1,2,3,0, one result per cycle; rsp_data 1FFFFFF,1FFFFFE,1FFFFFD,1FFFFFC.
3. Stall: rsp_ready=0 for 5 cycles with req_valid[2]=1 -> req_ready=0 throughout; rsp_data, rsp_id and rsp_valid unchanged. On rsp_ready=1, requester 2 is accepted in that same edge and the next result follows with no bubble.
4. Operands 0, 25'h1000000, 25'h1FFFFFF -> results 0, 25'h1000000, 25'd1. With TC_OVF_FLAG_EN, rsp_ovf = 0,1,0.
5. Assert rst_n=0 asynchronously (mid-cycle) while rsp_valid=1 and ptr=3 -> rsp_valid drops immediately. After release, with requesters 1 and 3 both valid, requester 1 is granted first (ptr=0).
6. Fairness: requester 0 always valid, requester 3 asserted once -> requester 3 granted within 3 grants and id sequence never repeats 0 past its turn.
